// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Row k = {in1,in2,in3}; its result lives in table bit 7-k.
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_e;

   localparam int NUM_ROWS = 8;
   localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);

   function automatic logic [2:0] row_bit(input logic [2:0] k);
      return LAST_ROW - k;
   endfunction

endpackage

// File: rtl/lut3_ref.sv
// Combinational 3-input reference gate defined by an 8-bit table.
// Output for row k = {in1,in2,in3} is TABLE[7-k].
module lut3_ref
   import tt_sweep_pkg::*;
#(
   parameter logic [7:0] TABLE = 8'h0E
) (
   input  logic in1_i,
   input  logic in2_i,
   input  logic in3_i,
   output logic out_o
);

   logic [2:0] row;

   // Table lookup for the current input row
   always_comb begin
      row   = {in1_i, in2_i, in3_i};
      out_o = TABLE[row_bit(row)];
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through rows 000..111 with a settle delay,
// captures its truth table and compares it with EXPECT.
module truth_table_sweeper
   import tt_sweep_pkg::*;
#(
   parameter logic [7:0]  EXPECT        = 8'h0E,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       dut_out,
   output logic       drv_in1,
   output logic       drv_in2,
   output logic       drv_in3,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] signature,
   output logic [7:0] mismatch
);

   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

   state_e     state_q, state_d;
   logic [2:0] row_q, row_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] sig_q, sig_d;
   logic [7:0] mis_q, mis_d;
   logic       pass_q, pass_d;
   logic [2:0] drv_q, drv_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   // Next-state, capture and registered-output decode
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      sig_d   = sig_q;
      mis_d   = mis_q;
      pass_d  = pass_q;
      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = SETTLE;
               row_d   = 3'd0;
               cnt_d   = CNT_LOAD;
               sig_d   = 8'h00;
               mis_d   = 8'h00;
               pass_d  = 1'b0;
            end
         end
         SETTLE: begin
            if (cnt_q == 8'd0) state_d = SAMPLE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         SAMPLE: begin
            sig_d[row_bit(row_q)] = dut_out;
            if (row_q == LAST_ROW) begin
               state_d = DONE;
               mis_d   = sig_d ^ EXPECT;
               pass_d  = (sig_d == EXPECT);
            end else begin
               state_d = SETTLE;
               row_d   = row_q + 3'd1;
               cnt_d   = CNT_LOAD;
            end
         end
         DONE: begin
            state_d = IDLE;
            row_d   = 3'd0;
         end
         default: state_d = IDLE;
      endcase
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         row_d   = 3'd0;
         cnt_d   = 8'd0;
         sig_d   = 8'h00;
         mis_d   = 8'h00;
         pass_d  = 1'b0;
      end
      busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
      done_d = (state_d == DONE);
      drv_d  = busy_d ? row_d : 3'b000;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= 3'd0;
         cnt_q   <= 8'd0;
         sig_q   <= 8'h00;
         mis_q   <= 8'h00;
         pass_q  <= 1'b0;
         drv_q   <= 3'b000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
         sig_q   <= sig_d;
         mis_q   <= mis_d;
         pass_q  <= pass_d;
         drv_q   <= drv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign {drv_in1, drv_in2, drv_in3} = drv_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = sig_q;
   assign mismatch  = mis_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default and fast sweeps,
// mismatch reporting, abort, ignored starts and async reset.
module tb_truth_table_sweeper;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       sel_0f = 1'b0;
   logic       dut_out;
   logic       out_0e, out_0f;
   logic       drv_in1, drv_in2, drv_in3;
   logic       busy, done, pass;
   logic [7:0] signature, mismatch;

   logic       start_f = 1'b0;
   logic       dut_out_f;
   logic       fin1, fin2, fin3;
   logic       fbusy, fdone, fpass;
   logic [7:0] fsig, fmis;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lut3_ref #(.TABLE(8'h0E)) u_ref_0e (
      .in1_i(drv_in1), .in2_i(drv_in2), .in3_i(drv_in3), .out_o(out_0e));
   lut3_ref #(.TABLE(8'h0F)) u_ref_0f (
      .in1_i(drv_in1), .in2_i(drv_in2), .in3_i(drv_in3), .out_o(out_0f));
   assign dut_out = sel_0f ? out_0f : out_0e;

   truth_table_sweeper u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .dut_out(dut_out), .drv_in1(drv_in1), .drv_in2(drv_in2),
      .drv_in3(drv_in3), .busy(busy), .done(done), .pass(pass),
      .signature(signature), .mismatch(mismatch));

   lut3_ref #(.TABLE(8'h0E)) u_ref_f (
      .in1_i(fin1), .in2_i(fin2), .in3_i(fin3), .out_o(dut_out_f));

   truth_table_sweeper #(.SETTLE_CYCLES(1)) u_fast (
      .clk(clk), .rst_n(rst_n), .start(start_f), .abort(1'b0),
      .dut_out(dut_out_f), .drv_in1(fin1), .drv_in2(fin2),
      .drv_in3(fin3), .busy(fbusy), .done(fdone), .pass(fpass),
      .signature(fsig), .mismatch(fmis));

   // start sampled at "edge 0"; the next negedge is in cycle 1
   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({drv_in1, drv_in2, drv_in3, busy, done, pass} !== 6'b0 ||
          signature !== 8'h00 || mismatch !== 8'h00) begin
         failures++;
         $display("FAIL reset_outputs: drv=%b%b%b busy=%b done=%b pass=%b sig=%h mis=%h, want all 0",
                  drv_in1, drv_in2, drv_in3, busy, done, pass, signature, mismatch);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_default_sweep();
      logic [2:0] exp_row;
      int bad_busy = 0, bad_done = 0, bad_row = 0;
      do_start();
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         exp_row = (c <= 40) ? 3'((c - 1) / 5) : 3'd0;
         if (busy !== (c <= 40)) bad_busy++;
         if (done !== (c == 41)) bad_done++;
         if ({drv_in1, drv_in2, drv_in3} !== exp_row) bad_row++;
         if (c == 41) begin
            checks++;
            if (signature !== 8'h0E || mismatch !== 8'h00 || pass !== 1'b1) begin
               failures++;
               $display("FAIL default_result: sig=%h mis=%h pass=%b, want 0e 00 1",
                        signature, mismatch, pass);
            end
         end
      end
      checks++;
      if (bad_busy != 0) begin
         failures++;
         $display("FAIL default_busy: %0d bad cycles, want 0", bad_busy);
      end
      checks++;
      if (bad_done != 0) begin
         failures++;
         $display("FAIL default_done: %0d bad cycles, want done only in cycle 41", bad_done);
      end
      checks++;
      if (bad_row != 0) begin
         failures++;
         $display("FAIL default_rows: %0d bad drive cycles, want 0", bad_row);
      end
   endtask

   task automatic test_mismatch();
      sel_0f = 1'b1;
      do_start();
      repeat (41) @(negedge clk);
      checks++;
      if (done !== 1'b1 || signature !== 8'h0F || mismatch !== 8'h01 ||
          pass !== 1'b0) begin
         failures++;
         $display("FAIL mismatch_result: done=%b sig=%h mis=%h pass=%b, want 1 0f 01 0",
                  done, signature, mismatch, pass);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (pass !== 1'b0 || mismatch !== 8'h01) begin
         failures++;
         $display("FAIL mismatch_hold: mis=%h pass=%b, want 01 0", mismatch, pass);
      end
      sel_0f = 1'b0;
   endtask

   task automatic test_fast_settle();
      logic [2:0] exp_row;
      int bad_row = 0, bad_done = 0;
      @(negedge clk);
      start_f = 1'b1;
      @(posedge clk);
      #1 start_f = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         exp_row = (c <= 16) ? 3'((c - 1) / 2) : 3'd0;
         if ({fin1, fin2, fin3} !== exp_row) bad_row++;
         if (fdone !== (c == 17)) bad_done++;
         if (c == 17) begin
            checks++;
            if (fsig !== 8'h0E || fpass !== 1'b1) begin
               failures++;
               $display("FAIL fast_result: sig=%h pass=%b, want 0e 1", fsig, fpass);
            end
         end
      end
      checks++;
      if (bad_row != 0) begin
         failures++;
         $display("FAIL fast_rows: %0d bad drive cycles, want 0", bad_row);
      end
      checks++;
      if (bad_done != 0) begin
         failures++;
         $display("FAIL fast_done: %0d bad cycles, want done only in cycle 17", bad_done);
      end
   endtask

   task automatic test_abort();
      int ndone = 0;
      do_start();
      repeat (13) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || {drv_in1, drv_in2, drv_in3} !== 3'd2) begin
         failures++;
         $display("FAIL abort_pre: busy=%b row=%b%b%b, want 1 010",
                  busy, drv_in1, drv_in2, drv_in3);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {drv_in1, drv_in2, drv_in3} !== 3'd0 ||
          signature !== 8'h00 || pass !== 1'b0) begin
         failures++;
         $display("FAIL abort_idle: busy=%b done=%b drv=%b%b%b sig=%h pass=%b, want 0 0 000 00 0",
                  busy, done, drv_in1, drv_in2, drv_in3, signature, pass);
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         failures++;
         $display("FAIL abort_quiet: %0d cycles with busy/done, want 0", ndone);
      end
      do_start();
      repeat (41) @(negedge clk);
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || signature !== 8'h0E) begin
         failures++;
         $display("FAIL abort_restart: done=%b pass=%b sig=%h, want 1 1 0e",
                  done, pass, signature);
      end
   endtask

   task automatic test_back_to_back();
      int ndone = 0, done_at = -1;
      @(negedge clk);
      do_start();
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            done_at = c;
         end
         if (c == 50) begin
            checks++;
            if (busy !== 1'b0 || pass !== 1'b1 || signature !== 8'h0E) begin
               failures++;
               $display("FAIL b2b_hold: busy=%b pass=%b sig=%h, want 0 1 0e",
                        busy, pass, signature);
            end
         end
         start = (c == 5 || c == 41);
      end
      start = 1'b0;
      checks++;
      if (ndone != 1 || done_at != 41) begin
         failures++;
         $display("FAIL b2b_done: count=%0d at=%0d, want 1 at 41", ndone, done_at);
      end
      do_start();
      @(negedge clk);
      checks++;
      if (pass !== 1'b0 || signature !== 8'h00 || busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_clear: pass=%b sig=%h busy=%b, want 0 00 1",
                  pass, signature, busy);
      end
      repeat (45) @(negedge clk);
   endtask

   task automatic test_async_reset();
      do_start();
      repeat (30) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || signature !== 8'h08 ||
          {drv_in1, drv_in2, drv_in3} !== 3'd5) begin
         failures++;
         $display("FAIL rst_pre: busy=%b sig=%h row=%b%b%b, want 1 08 101",
                  busy, signature, drv_in1, drv_in2, drv_in3);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({drv_in1, drv_in2, drv_in3, busy, done, pass} !== 6'b0 ||
          signature !== 8'h00 || mismatch !== 8'h00) begin
         failures++;
         $display("FAIL rst_async: drv=%b%b%b busy=%b done=%b pass=%b sig=%h mis=%h, want all 0",
                  drv_in1, drv_in2, drv_in3, busy, done, pass, signature, mismatch);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      do_start();
      repeat (41) @(negedge clk);
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || signature !== 8'h0E ||
          mismatch !== 8'h00) begin
         failures++;
         $display("FAIL rst_recover: done=%b pass=%b sig=%h mis=%h, want 1 1 0e 00",
                  done, pass, signature, mismatch);
      end
   endtask

   initial begin
      test_reset();
      test_default_sweep();
      test_mismatch();
      test_fast_settle();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
